// File: rtl/tdp_ram18k_port_initiator.sv
// tdp_ram18k_port_initiator
// Drives one 18-bit port (16 data + 2 parity) of a RAM18KX2 true-dual-port RAM
// from a valid/ready request stream. Writes get per-byte parity generated,
// reads get parity checked and are returned in order through a small
// first-word-fall-through response FIFO. Read credits bound the number of
// outstanding reads so the FIFO can never overflow.
// Optional build macro: TDP_RAM18K_PORT_ERR_CNT_EN adds a saturating parity
// error counter (ERR_COUNT) with a synchronous clear (ERR_CLR).
module tdp_ram18k_port_initiator #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [9:0]  REQ_ADDR,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_RDATA,
  output logic [1:0]  RSP_PERR,
  output logic        RAM_WEN,
  output logic        RAM_REN,
  output logic [1:0]  RAM_BE,
  output logic [13:0] RAM_ADDR,
  output logic [15:0] RAM_WDATA,
  output logic [1:0]  RAM_WPARITY,
  input  logic [15:0] RAM_RDATA,
  input  logic [1:0]  RAM_RPARITY
`ifdef TDP_RAM18K_PORT_ERR_CNT_EN
  ,
  output logic [15:0] ERR_COUNT,
  input  logic        ERR_CLR
`endif
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Only power-of-two depths 2/4/8 are supported; pointers wrap naturally.
  generate
    if (RSP_DEPTH != 2 && RSP_DEPTH != 4 && RSP_DEPTH != 8) begin : g_bad_depth
      $error("tdp_ram18k_port_initiator: RSP_DEPTH must be 2, 4 or 8");
    end
  endgenerate

  logic             accept;
  logic             rd_accept;
  logic             wr_accept;
  logic [1:0]       wpar_next;
  logic [1:0]       perr_next;

  logic             wen_reg;
  logic             ren_reg;
  logic [1:0]       be_reg;
  logic [13:0]      addr_reg;
  logic [15:0]      wdata_reg;
  logic [1:0]       wpar_reg;
  logic             s2_valid_reg;

  logic [17:0]      fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;
  logic [CNT_W-1:0] out_cnt_reg;
  logic             push;
  logic             pop;
  logic             fifo_full;

  // Ready depends only on registered credit count (and reset), never on request fields.
  assign REQ_READY = RESET_N && (out_cnt_reg < CNT_W'(RSP_DEPTH));
  assign accept    = REQ_VALID && REQ_READY;
  assign rd_accept = accept && !REQ_WRITE;
  assign wr_accept = accept && REQ_WRITE;

  // Per-byte parity generation for writes and checking for read returns.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_par
      assign wpar_next[gi] = (^REQ_WDATA[8*gi +: 8]) ^ PARITY_ODD;
      assign perr_next[gi] = RAM_RPARITY[gi] ^ (^RAM_RDATA[8*gi +: 8]) ^ PARITY_ODD;
    end
  endgenerate

  // Stage 1: register the accepted request onto the RAM pins for one cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wen_reg   <= 1'b0;
      ren_reg   <= 1'b0;
      be_reg    <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wpar_reg  <= 2'b00;
    end else begin
      wen_reg <= wr_accept;
      ren_reg <= rd_accept;
      be_reg  <= wr_accept ? REQ_BE : 2'b00;
      if (accept) begin
        addr_reg  <= {REQ_ADDR, 4'b0000};
        wdata_reg <= REQ_WRITE ? REQ_WDATA : 16'h0000;
        wpar_reg  <= REQ_WRITE ? wpar_next : 2'b00;
      end
    end
  end

  assign RAM_WEN     = wen_reg;
  assign RAM_REN     = ren_reg;
  assign RAM_BE      = be_reg;
  assign RAM_ADDR    = addr_reg;
  assign RAM_WDATA   = wdata_reg;
  assign RAM_WPARITY = wpar_reg;

  // Stage 2: mark the cycle in which the RAM presents read data for a read we issued.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid_reg <= 1'b0;
    end else begin
      s2_valid_reg <= ren_reg;
    end
  end

  assign push      = s2_valid_reg;
  assign RSP_VALID = (fifo_cnt_reg != '0);
  assign pop       = RSP_VALID && RSP_READY;
  assign fifo_full = (fifo_cnt_reg == CNT_W'(RSP_DEPTH));

  // Response FIFO storage; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {RAM_RDATA, perr_next};
    end
  end

  // FIFO pointers/occupancy and the outstanding-read credit counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      out_cnt_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
      case ({rd_accept, pop})
        2'b10:   out_cnt_reg <= out_cnt_reg + CNT_W'(1);
        2'b01:   out_cnt_reg <= out_cnt_reg - CNT_W'(1);
        default: out_cnt_reg <= out_cnt_reg;
      endcase
    end
  end

  assign RSP_RDATA = RSP_VALID ? fifo_mem[rd_ptr_reg][17:2] : 16'h0000;
  assign RSP_PERR  = RSP_VALID ? fifo_mem[rd_ptr_reg][1:0]  : 2'b00;

  // A push into a full FIFO without a simultaneous pop means the credit scheme broke.
  assert property (@(posedge CLK) disable iff (!RESET_N) !(push && fifo_full && !pop))
    else $error("tdp_ram18k_port_initiator: push into full response FIFO");

`ifdef TDP_RAM18K_PORT_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Saturating count of popped responses carrying a parity error; clear has priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_cnt_reg <= 16'h0000;
    end else if (ERR_CLR) begin
      err_cnt_reg <= 16'h0000;
    end else if (pop && (RSP_PERR != 2'b00) && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'h0001;
    end
  end

  assign ERR_COUNT = err_cnt_reg;
`endif

endmodule

// File: tb/tb_tdp_ram18k_port_initiator.sv
// tb_tdp_ram18k_port_initiator
// Scoreboard bench: a behavioural RAM18K port model answers the RAM pins, a
// shadow memory predicts read data, expected responses are queued on accept
// and compared when the DUT pops them.
module tb_tdp_ram18k_port_initiator;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [9:0]  REQ_ADDR;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_RDATA;
  logic [1:0]  RSP_PERR;
  logic        RAM_WEN;
  logic        RAM_REN;
  logic [1:0]  RAM_BE;
  logic [13:0] RAM_ADDR;
  logic [15:0] RAM_WDATA;
  logic [1:0]  RAM_WPARITY;
  logic [15:0] RAM_RDATA;
  logic [1:0]  RAM_RPARITY;
`ifdef TDP_RAM18K_PORT_ERR_CNT_EN
  logic [15:0] ERR_COUNT;
  logic        ERR_CLR = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic        flip_par = 1'b0;
  logic [15:0] ram_data [1024];
  logic [1:0]  ram_par  [1024];
  logic [15:0] shadow   [1024];
  logic [17:0] exp_q [$];

  tdp_ram18k_port_initiator #(.PARITY_ODD(1'b0), .RSP_DEPTH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_PERR(RSP_PERR),
    .RAM_WEN(RAM_WEN), .RAM_REN(RAM_REN), .RAM_BE(RAM_BE), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_WPARITY(RAM_WPARITY),
    .RAM_RDATA(RAM_RDATA), .RAM_RPARITY(RAM_RPARITY)
`ifdef TDP_RAM18K_PORT_ERR_CNT_EN
    , .ERR_COUNT(ERR_COUNT), .ERR_CLR(ERR_CLR)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM port: byte-masked writes, registered read with optional parity corruption.
  always @(posedge CLK) begin
    if (RAM_WEN) begin
      if (RAM_BE[0]) begin
        ram_data[RAM_ADDR[13:4]][7:0] <= RAM_WDATA[7:0];
        ram_par[RAM_ADDR[13:4]][0]    <= RAM_WPARITY[0];
      end
      if (RAM_BE[1]) begin
        ram_data[RAM_ADDR[13:4]][15:8] <= RAM_WDATA[15:8];
        ram_par[RAM_ADDR[13:4]][1]     <= RAM_WPARITY[1];
      end
    end
    if (RAM_REN) begin
      RAM_RDATA   <= ram_data[RAM_ADDR[13:4]];
      RAM_RPARITY <= ram_par[RAM_ADDR[13:4]] ^ {1'b0, flip_par};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: sampled mid-cycle, the pop happens at the next rising edge.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(RSP_RDATA), 32'hFFFF_FFFF);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        $display("rsp  rdata=%04h perr=%b (expected %04h/%b)", RSP_RDATA, RSP_PERR, e[17:2], e[1:0]);
        chk("rsp_rdata", 32'(RSP_RDATA), 32'(e[17:2]));
        chk("rsp_perr",  32'(RSP_PERR),  32'(e[1:0]));
      end
    end
  end

  // Offer one request until accepted; returns one cycle after the accept edge.
  task automatic send(input bit wr, input int a, input logic [1:0] be, input logic [15:0] d);
    int n = 0;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = 10'(a); REQ_BE = be; REQ_WDATA = d;
    while (!REQ_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!REQ_READY) begin
      chk("req_ready_timeout", 32'(REQ_READY), 1);
      REQ_VALID = 1'b0;
      return;
    end
    if (wr) begin
      if (be[0]) shadow[a][7:0]  = d[7:0];
      if (be[1]) shadow[a][15:8] = d[15:8];
      $display("req  write addr=%03h be=%b data=%04h", a, be, d);
    end else begin
      exp_q.push_back({shadow[a], 1'b0, flip_par});
      $display("req  read  addr=%03h", a);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    REQ_VALID = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge CLK); #1; n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_data[i] = 16'h0000; ram_par[i] = 2'b00; shadow[i] = 16'h0000;
    end
    RAM_RDATA = 16'h0000; RAM_RPARITY = 2'b00;
    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0;
    REQ_BE = 2'b00; REQ_WDATA = '0; RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(REQ_READY), 0);
    chk("rst_ram_wen",   32'(RAM_WEN), 0);
    chk("rst_ram_ren",   32'(RAM_REN), 0);
    chk("rst_ram_addr",  32'(RAM_ADDR), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_ready", 32'(REQ_READY), 1);

    // Full write: parity 0x13 -> 1, 0x01 -> 1
    send(1'b1, 10'h005, 2'b11, 16'h1301);
    idle();
    chk("wr_wen",   32'(RAM_WEN), 1);
    chk("wr_addr",  32'(RAM_ADDR), 'h0050);
    chk("wr_wpar",  32'(RAM_WPARITY), 'b11);
    chk("wr_be",    32'(RAM_BE), 'b11);
    chk("wr_wdata", 32'(RAM_WDATA), 'h1301);
    @(posedge CLK); #1;
    chk("idle_wen",  32'(RAM_WEN), 0);
    chk("idle_be",   32'(RAM_BE), 0);
    chk("idle_addr", 32'(RAM_ADDR), 'h0050);

    // Read latency: REN in cycle 1, response visible in cycle 3
    send(1'b0, 10'h005, 2'b00, 16'h0000);
    idle();
    chk("rd_ren_c1",   32'(RAM_REN), 1);
    chk("rd_be_c1",    32'(RAM_BE), 0);
    chk("rd_wdata_c1", 32'(RAM_WDATA), 0);
    @(posedge CLK); #1;
    chk("rsp_valid_c2", 32'(RSP_VALID), 0);
    @(posedge CLK); #1;
    chk("rsp_valid_c3", 32'(RSP_VALID), 1);
    drain(20);

    // Corrupted parity bit 0 on return
    flip_par = 1'b1;
    send(1'b0, 10'h005, 2'b00, 16'h0000);
    idle();
    drain(20);
    flip_par = 1'b0;
`ifdef TDP_RAM18K_PORT_ERR_CNT_EN
    chk("err_count", 32'(ERR_COUNT), 1);
`endif

    // BE=00 write pulses WEN but changes nothing
    send(1'b1, 10'h005, 2'b00, 16'hDEAD);
    idle();
    chk("be0_wen", 32'(RAM_WEN), 1);
    chk("be0_be",  32'(RAM_BE), 0);
    send(1'b0, 10'h005, 2'b00, 16'h0000);
    idle();
    drain(20);

    // Back-pressure: fill addresses 0..3, then offer 6 reads with RSP_READY low
    for (int i = 0; i < 4; i++) send(1'b1, i, 2'b11, 16'hA000 + 16'(i));
    idle();
    RSP_READY = 1'b0;
    begin
      int acc = 0;
      int a = 0;
      for (int c = 0; c < 12; c++) begin
        bit took;
        REQ_VALID = (a < 6); REQ_WRITE = 1'b0; REQ_ADDR = 10'(a);
        took = REQ_VALID && REQ_READY;
        if (took) begin
          exp_q.push_back({shadow[a], 2'b00});
          $display("req  read  addr=%03h (back-pressure)", a);
        end
        @(posedge CLK); #1;
        if (took) begin a++; acc++; end
      end
      chk("bp_accepted", 32'(acc), 4);
      chk("bp_req_ready", 32'(REQ_READY), 0);
    end
    idle();
    RSP_READY = 1'b1;
    drain(30);
    chk("bp_ready_back", 32'(REQ_READY), 1);

    // Partial write at top address, read-after-write, then wrap to address 0
    send(1'b1, 10'h3FF, 2'b10, 16'hFF00);
    chk("pw_be",   32'(RAM_BE), 'b10);
    chk("pw_addr", 32'(RAM_ADDR), 'h3FF0);
    send(1'b0, 10'h3FF, 2'b00, 16'h0000);
    send(1'b0, 10'h000, 2'b00, 16'h0000);
    idle();
    chk("wrap_addr", 32'(RAM_ADDR), 'h0000);
    chk("wrap_ren",  32'(RAM_REN), 1);
    drain(20);

    // Reset with two reads in flight
    send(1'b0, 10'h001, 2'b00, 16'h0000);
    send(1'b0, 10'h002, 2'b00, 16'h0000);
    idle();
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("mid_rst_ram_ren",   32'(RAM_REN), 0);
    chk("mid_rst_req_ready", 32'(REQ_READY), 0);
    exp_q.delete();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("rel_req_ready", 32'(REQ_READY), 1);
    repeat (8) @(posedge CLK);
    #1;
    chk("rel_rsp_valid", 32'(RSP_VALID), 0);
    chk("final_queue", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
